// File: rtl/div_unit_r32m.sv
// div_unit_r32m: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle (32 CALC cycles) followed by one sign-fix cycle.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow are
// resolved at start and go straight to DONE without entering CALC/FIX.
module div_unit_r32m #(
    parameter int dataW = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       divop,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [dataW-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [dataW-1:0] MIN_NEG = {1'b1, {(dataW-1){1'b0}}};
    localparam logic [dataW-1:0] ALL_ONE = {dataW{1'b1}};
    localparam logic [dataW-1:0] ONE     = {{(dataW-1){1'b0}}, 1'b1};

    // Two's-complement negation.
    function automatic logic [dataW-1:0] neg_f(input logic [dataW-1:0] x);
        return ~x + ONE;
    endfunction

    // Magnitude of an operand when the operation is signed, raw value otherwise.
    function automatic logic [dataW-1:0] mag_f(input logic [dataW-1:0] x,
                                               input logic            is_signed);
        logic signed [dataW-1:0] sx;
        sx = $signed(x);
        return (is_signed && (sx < 0)) ? neg_f(x) : x;
    endfunction

    state_t           r_state;
    logic [4:0]       r_cnt;
    logic [dataW-1:0] r_quo;      // dividend shifts out, quotient shifts in
    logic [dataW-1:0] r_rem;      // partial remainder
    logic [dataW-1:0] r_dvsr;     // divisor magnitude
    logic [dataW-1:0] r_a;        // raw dividend, remainder for divide-by-zero
    logic             r_qneg;
    logic             r_rneg;
    logic             r_sel_rem;  // divop[1]: output the remainder
    logic             r_dz;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [dataW-1:0] r_result;

    logic             w_accepting;
    logic             w_signed;
    logic             w_dz;
    logic             w_ovf;
    logic             w_take_fast;
    logic [dataW:0]   w_trial;
    logic [dataW-1:0] w_fix_q;
    logic [dataW-1:0] w_fix_r;
    logic [dataW-1:0] w_fix_result;
    logic [dataW-1:0] w_fast_result;

    assign w_accepting = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_signed    = ~divop[0];
    assign w_dz        = (B == '0);
    assign w_ovf       = w_signed && (A == MIN_NEG) && (B == ALL_ONE);

`ifdef DIV_FASTPATH_EN
    assign w_take_fast = w_dz || w_ovf;
`else
    assign w_take_fast = 1'b0;
`endif

    // Trial subtraction: {rem, next dividend bit} - divisor. Since rem < divisor,
    // the 33-bit difference carries a reliable sign in its MSB.
    assign w_trial = {r_rem, r_quo[dataW-1]} - {1'b0, r_dvsr};

    // Sign correction and architectural special-case overrides for the FIX cycle.
    always_comb begin
        w_fix_q = r_qneg ? neg_f(r_quo) : r_quo;
        w_fix_r = r_rneg ? neg_f(r_rem) : r_rem;
        if (r_dz) begin
            w_fix_q = ALL_ONE;
            w_fix_r = r_a;
        end else if (r_ovf) begin
            w_fix_q = MIN_NEG;
            w_fix_r = '0;
        end
        w_fix_result = r_sel_rem ? w_fix_r : w_fix_q;
    end

    // Result for a special case resolved at start (only selected in the fast build).
    always_comb begin
        w_fast_result = '0;
        if (w_dz) begin
            w_fast_result = divop[1] ? A : ALL_ONE;
        end else begin
            w_fast_result = divop[1] ? '0 : MIN_NEG;
        end
    end

    // Control FSM and iteration datapath; reset clears every register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvsr    <= '0;
            r_a       <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_sel_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accepting && start) begin
                        r_cnt     <= '0;
                        r_quo     <= mag_f(A, w_signed);
                        r_rem     <= '0;
                        r_dvsr    <= mag_f(B, w_signed);
                        r_a       <= A;
                        r_qneg    <= w_signed && (A[dataW-1] ^ B[dataW-1]);
                        r_rneg    <= w_signed && A[dataW-1];
                        r_sel_rem <= divop[1];
                        r_dz      <= w_dz;
                        r_ovf     <= w_ovf;
                        if (w_take_fast) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_fast_result;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (!w_trial[dataW]) begin
                        r_rem <= w_trial[dataW-1:0];
                    end else begin
                        r_rem <= {r_rem[dataW-2:0], r_quo[dataW-1]};
                    end
                    r_quo <= {r_quo[dataW-2:0], ~w_trial[dataW]};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_div_unit_r32m.sv
// Testbench for div_unit_r32m: table-driven vectors plus hand-written
// sequences for ignored start, back-to-back, and reset corner cases.
module tb_div_unit_r32m;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  divop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_fail;

`ifdef DIV_FASTPATH_EN
    localparam int SPECIAL_BUSY = 0;
`else
    localparam int SPECIAL_BUSY = 33;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
    } vec_t;

    vec_t vecs[17];

    div_unit_r32m #(.dataW(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .divop  (divop),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Present an operation and let it be sampled on the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        divop = op;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, counting busy cycles; optionally pulse start (A=1,B=1) at sample 'inject'.
    task automatic wait_done(input string nm, input logic [31:0] exp_res,
                             input int exp_busy, input int inject);
        int nbusy;
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (i == inject) begin
                start = 1'b1;
                A     = 32'd1;
                B     = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        chk({nm, " done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({nm, " result"}, result, exp_res);
            chk({nm, " busy_cycles"}, nbusy, exp_busy);
            chk({nm, " busy_in_done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    // Count done pulses over a window of cycles.
    task automatic count_done(input int cycles, output int ndone);
        ndone = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
    endtask

    initial begin
        int nd;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        divop    = 2'b00;
        A        = '0;
        B        = '0;

        vecs[0]  = '{OP_DIV,  32'd18,         32'd4,          32'd4,          1'b0};
        vecs[1]  = '{OP_REM,  32'd18,         32'd4,          32'd2,          1'b0};
        vecs[2]  = '{OP_DIV,  32'd18,         32'hFFFFFFFC,   32'hFFFFFFFC,   1'b0};
        vecs[3]  = '{OP_REM,  32'd18,         32'hFFFFFFFC,   32'd2,          1'b0};
        vecs[4]  = '{OP_REM,  32'hFFFFFFEE,   32'd4,          32'hFFFFFFFE,   1'b0};
        vecs[5]  = '{OP_DIV,  32'hFFFFFFEE,   32'd4,          32'hFFFFFFFC,   1'b0};
        vecs[6]  = '{OP_DIV,  32'hFFFFFFEE,   32'hFFFFFFFC,   32'd4,          1'b0};
        vecs[7]  = '{OP_REM,  32'hFFFFFFEE,   32'hFFFFFFFC,   32'hFFFFFFFE,   1'b0};
        vecs[8]  = '{OP_DIVU, 32'd7,          32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[9]  = '{OP_REM,  32'd7,          32'd0,          32'd7,          1'b1};
        vecs[10] = '{OP_DIVU, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   1'b0};
        vecs[11] = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
        vecs[12] = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1};
        vecs[13] = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[14] = '{OP_DIV,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[15] = '{OP_REM,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1'b1};
        vecs[16] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset busy",   {31'd0, busy}, 32'd0);
        chk("reset done",   {31'd0, done}, 32'd0);
        chk("reset result", result,        32'd0);

        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].exp,
                      vecs[i].special ? SPECIAL_BUSY : 33, -1);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d done_drop", i), {31'd0, done}, 32'd0);
            chk($sformatf("vec%0d held", i), result, vecs[i].exp);
        end

        // start during CALC is ignored; then back-to-back start in the DONE cycle
        issue(OP_DIV, 32'd100, 32'd7);
        wait_done("ignored_start", 32'd14, 33, 10);
        issue(OP_DIVU, 32'd18, 32'd4);
        chk("b2b done_drop", {31'd0, done}, 32'd0);
        chk("b2b busy_rise", {31'd0, busy}, 32'd1);
        wait_done("b2b", 32'd4, 33, -1);
        count_done(40, nd);
        chk("no_extra_done", nd, 32'd0);

        // reset in the middle of CALC
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (15) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midreset busy",   {31'd0, busy}, 32'd0);
        chk("midreset done",   {31'd0, done}, 32'd0);
        chk("midreset result", result,        32'd0);
        count_done(40, nd);
        chk("midreset no_done", nd, 32'd0);
        issue(OP_DIVU, 32'd18, 32'd4);
        wait_done("after_reset", 32'd4, 33, -1);

        // reset and start on the same edge: reset wins
        divop = OP_DIV;
        A     = 32'd18;
        B     = 32'd4;
        start = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        reset = 1'b0;
        chk("rst_start busy",   {31'd0, busy}, 32'd0);
        chk("rst_start result", result,        32'd0);
        count_done(40, nd);
        chk("rst_start no_done", nd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
